// File: rtl/vector_response_checker.sv
// Exhaustive 4-input vector sweep with per-vector response check.
// Optional MISR signature output when MISR_SIGNATURE_EN is defined.
module vector_response_checker #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        CK,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden,
  input  logic        dut_out,
  output logic [0:3]  N,
  output logic        busy,
  output logic        done,
  output logic [4:0]  mismatch_cnt,
  output logic [15:0] fail_map,
  output logic [3:0]  first_fail,
`ifdef MISR_SIGNATURE_EN
  output logic [15:0] signature,
`endif
  output logic        pass
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic       NO_SETTLE = (SETTLE_CYC == 0);

  state_t     state;
  state_t     state_nx;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       go;
  logic       miss;
  logic       last;

  assign busy = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (mismatch_cnt == 5'd0);
  assign go   = start && ((state == IDLE) || (state == DONE));
  assign miss = dut_out != golden[idx];
  assign last = (idx == 4'd15);

  // State register
  always_ff @(posedge CK) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: start wins in IDLE/DONE, abort wins while busy
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = APPLY;
      end
      APPLY: begin
        if (abort)          state_nx = IDLE;
        else if (NO_SETTLE) state_nx = SAMPLE;
        else                state_nx = SETTLE;
      end
      SETTLE: begin
        if (abort)           state_nx = IDLE;
        else if (cnt <= 4'd1) state_nx = SAMPLE;
      end
      SAMPLE: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
        else           state_nx = APPLY;
      end
      DONE: begin
        if (start) state_nx = APPLY;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: index, settle counter, stimulus and result registers
  always_ff @(posedge CK) begin
    if (reset) begin
      idx          <= '0;
      cnt          <= '0;
      N            <= '0;
      mismatch_cnt <= '0;
      fail_map     <= '0;
      first_fail   <= '0;
    end else if (go) begin
      idx          <= '0;
      cnt          <= '0;
      N            <= '0;
      mismatch_cnt <= '0;
      fail_map     <= '0;
      first_fail   <= '0;
    end else if (busy && abort) begin
      N <= '0;
    end else begin
      unique case (state)
        APPLY: begin
          cnt <= SETTLE_LD;
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          if (miss) begin
            fail_map[idx] <= 1'b1;
            mismatch_cnt  <= mismatch_cnt + 5'd1;
            if (mismatch_cnt == 5'd0) first_fail <= idx;
          end
          if (last) begin
            N <= '0;
          end else begin
            idx <= idx + 4'd1;
            N   <= idx + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MISR_SIGNATURE_EN
  logic [15:0] sig_nx;

  // CCITT MISR step absorbing {N, dut_out}
  always_comb begin
    sig_nx = {signature[14:0], 1'b0};
    if (signature[15]) sig_nx = sig_nx ^ 16'h1021;
    sig_nx = sig_nx ^ {11'd0, N, dut_out};
  end

  // Signature register: seeded at sweep start, updated per sample
  always_ff @(posedge CK) begin
    if (reset) begin
      signature <= '0;
    end else if (go) begin
      signature <= 16'hFFFF;
    end else if ((state == SAMPLE) && !abort) begin
      signature <= sig_nx;
    end
  end
`endif

endmodule

// File: tb/tb_vector_response_checker.sv
// Bench: three checker instances (settle 0, 1, 15) driven together,
// table and random sweeps against a parity-DUT reference model.
module tb_vector_response_checker;

  localparam int SC[3] = '{0, 1, 15};
  localparam int MAXL  = 16 * (15 + 2);

  logic        CK = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] golden;
  logic [15:0] mask;

  logic [0:3]  n_o[3];
  logic        busy_o[3];
  logic        done_o[3];
  logic [4:0]  cnt_o[3];
  logic [15:0] map_o[3];
  logic [3:0]  first_o[3];
  logic        pass_o[3];
  logic        dout[3];
`ifdef MISR_SIGNATURE_EN
  logic [15:0] sig_o[3];
`endif

  int checks   = 0;
  int failures = 0;
  bit seq_ok[3];

  logic [15:0] exp_map;
  int          exp_cnt;
  int          exp_first;

  always #5 CK = ~CK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    // DUT under test: 4-input XOR, inverted where mask bit is set
    assign dout[g] = (^n_o[g]) ^ mask[n_o[g]];

    vector_response_checker #(.SETTLE_CYC(SC[g])) u_dut (
      .CK           (CK),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .golden       (golden),
      .dut_out      (dout[g]),
      .N            (n_o[g]),
      .busy         (busy_o[g]),
      .done         (done_o[g]),
      .mismatch_cnt (cnt_o[g]),
      .fail_map     (map_o[g]),
      .first_fail   (first_o[g]),
`ifdef MISR_SIGNATURE_EN
      .signature    (sig_o[g]),
`endif
      .pass         (pass_o[g])
    );
  end

  typedef struct {
    logic [15:0] g;
    logic [15:0] m;
    logic [15:0] map;
    int          cnt;
    int          first;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: vector k fails when parity(k)^mask[k] differs from golden[k]
  task automatic model(input logic [15:0] g, input logic [15:0] m);
    exp_map   = '0;
    exp_cnt   = 0;
    exp_first = 0;
    for (int k = 15; k >= 0; k--) begin
      logic r;
      r = ($countones(4'(k)) % 2 == 1) ^ m[k];
      if (r != g[k]) begin
        exp_map[k] = 1'b1;
        exp_cnt++;
        exp_first = k;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_n"},     int'(n_o[i]),    0);
      chk({tag, "_busy"},  int'(busy_o[i]), 0);
      chk({tag, "_done"},  int'(done_o[i]), 0);
      chk({tag, "_cnt"},   int'(cnt_o[i]),  0);
      chk({tag, "_map"},   int'(map_o[i]),  0);
      chk({tag, "_first"}, int'(first_o[i]), 0);
      chk({tag, "_pass"},  int'(pass_o[i]), 0);
    end
  endtask

  task automatic step_check(input int e);
    for (int i = 0; i < 3; i++) begin
      int L;
      L = 16 * (SC[i] + 2);
      if (e < L) begin
        if (!(busy_o[i] && !done_o[i] &&
              int'(n_o[i]) == e / (SC[i] + 2)))
          seq_ok[i] = 1'b0;
      end else begin
        if (!(done_o[i] && !busy_o[i] && n_o[i] == 4'd0))
          seq_ok[i] = 1'b0;
      end
      if (e == L) begin
        chk($sformatf("map%0d", i),   int'(map_o[i]),   int'(exp_map));
        chk($sformatf("cnt%0d", i),   int'(cnt_o[i]),   exp_cnt);
        chk($sformatf("first%0d", i), int'(first_o[i]), exp_first);
        chk($sformatf("pass%0d", i),  int'(pass_o[i]),
            int'(exp_cnt == 0));
      end
    end
  endtask

  // One full sweep; start held high for `hold` cycles, optional abort
  task automatic run_sweep(input logic [15:0] g, input logic [15:0] m,
                           input int hold, input bit ab);
    golden = g;
    mask   = m;
    model(g, m);
    for (int i = 0; i < 3; i++) seq_ok[i] = 1'b1;
    @(negedge CK);
    start = 1'b1;
    abort = ab;
    @(negedge CK);
    abort = 1'b0;
    for (int e = 0; e <= MAXL; e++) begin
      if (e >= hold) start = 1'b0;
      step_check(e);
      if (e < MAXL) @(negedge CK);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("timing_seq%0d", i), int'(seq_ok[i]), 1);
  endtask

  task automatic abort_test();
    golden = 16'h6996;
    mask   = 16'hFFFF;
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    for (int e = 0; e < 21; e++) @(negedge CK);
    chk("abort_pre_n1", int'(n_o[1]), 7);
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_busy%0d", i), int'(busy_o[i]), 0);
      chk($sformatf("abort_done%0d", i), int'(done_o[i]), 0);
      chk($sformatf("abort_n%0d", i),    int'(n_o[i]),    0);
    end
    chk("abort_map1", int'(map_o[1]), 16'h007F);
    chk("abort_cnt1", int'(cnt_o[1]), 7);
    chk("abort_map2", int'(map_o[2]), 16'h0001);
    chk("abort_cnt2", int'(cnt_o[2]), 1);
    @(negedge CK);
    chk("abort_idle_busy1", int'(busy_o[1]), 0);
  endtask

  task automatic reset_mid_test();
    golden = 16'h6996;
    mask   = 16'hFFFF;
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    for (int e = 0; e < 20; e++) @(negedge CK);
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge CK);
    chk_zero("rst_mid");
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h6996, 16'h0000, 16'h0000, 0,  0};
    tbl[1] = '{16'h6996, 16'h1020, 16'h1020, 2,  5};
    tbl[2] = '{16'h6996, 16'hFFFF, 16'hFFFF, 16, 0};
    tbl[3] = '{16'h0000, 16'h0000, 16'h6996, 8,  1};

    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    golden = '0;
    mask   = '0;
    repeat (2) @(negedge CK);
    chk_zero("reset");
    reset = 1'b0;

    for (int t = 0; t < 4; t++) begin
      model(tbl[t].g, tbl[t].m);
      chk($sformatf("tbl%0d_model_map", t), int'(exp_map), int'(tbl[t].map));
      chk($sformatf("tbl%0d_model_cnt", t), exp_cnt, tbl[t].cnt);
      chk($sformatf("tbl%0d_model_first", t), exp_first, tbl[t].first);
      run_sweep(tbl[t].g, tbl[t].m, 1, 1'b0);
    end

    run_sweep(16'h6996, 16'h1020, 31, 1'b0);
    run_sweep(16'h6996, 16'h0400, 1, 1'b1);

    abort_test();
    run_sweep(16'h6996, 16'h1020, 1, 1'b0);

    for (int r = 0; r < 6; r++)
      run_sweep(16'($urandom), 16'($urandom), 1, 1'b0);

    reset_mid_test();
    run_sweep(16'h6996, 16'h8001, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
